watchdog: RTL
=============

Name: watchdog

Overview:
- Decoder watchdog timer: supervises decoder progress and generates `watchdog_rst`, the active-low, clk-synchronous watchdog reset consumed by the reset generator.
- If no progress strobe (`kick`) arrives within a programmable interval, it drives `watchdog_rst` low for a fixed pulse, then re-arms.
- Its own `rst` is driven from the hard reset (inverted to active-high). Interval and status registers therefore survive the watchdog-induced reset they cause.

Parameters:
- PRESCALE_BITS, 16, prescaler width; one timer tick every 2^PRESCALE_BITS clk cycles.
- PULSE_LEN, 4, `watchdog_rst` low duration in clk cycles; must be ≥3 (FIFO reset rule).
- CNT_WIDTH, 8, width of the saturating expiry counter.

Ports:
- clk  input  1  decoder clock
- rst  input  1  reset, synchronous, active-high; connected to inverted `hard_rst`
- kick  input  1  decoder progress strobe, one cycle; restarts timeout
- interval  input  8  timeout in ticks; 0 = watchdog disabled
- interval_wr  input  1  load `interval` into interval register
- status_rd  input  1  status read strobe; clears `watchdog_status` and `expire_cnt`
- watchdog_rst  output  1  active-low watchdog reset, registered
- watchdog_status  output  1  sticky; 1 = watchdog fired since last `status_rd`
- expire_cnt  output  CNT_WIDTH  number of expiries since last `status_rd`, saturating

Behaviour:
- Reset (rst=1 at clock edge):
  - `watchdog_rst`=1, `watchdog_status`=0, `expire_cnt`=0.
  - Interval register=0, prescaler=0, down-counter=0, state DISABLED.
- Registers:
  - interval_reg[7:0].
  - prescaler[PRESCALE_BITS-1:0], free-running in RUNNING.
  - down-counter[7:0].
  - pulse counter sized for PULSE_LEN.
- Tick: asserted in a cycle where prescaler = all-ones; the prescaler wraps to 0.
- State DISABLED:
  - `watchdog_rst`=1; `kick` ignored.
  - `interval_wr` with nonzero value → RUNNING: prescaler=0, counter=`interval`.
  - `interval_wr` with 0 → stays DISABLED.
- State RUNNING:
  - `kick` → prescaler=0, counter=interval_reg.
  - Tick with counter>1 → counter−1.
  - Tick with counter=1 and no `kick` → FIRE.
  - `interval_wr` with 0 → DISABLED.
  - `interval_wr` with nonzero value → reload prescaler=0, counter=new value.
- Timing: with `kick` (or a nonzero `interval_wr`) sampled at edge E0 and no further `kick`/`interval_wr`, `watchdog_rst` is first low after edge E0 + interval·2^PRESCALE_BITS. It stays low exactly PULSE_LEN cycles.
- State FIRE:
  - `watchdog_rst`=0; `kick` ignored.
  - On entry: `watchdog_status`←1, `expire_cnt`←`expire_cnt`+1, saturating at all-ones.
  - After PULSE_LEN cycles: `watchdog_rst`←1; go to RUNNING with prescaler=0, counter=interval_reg, or to DISABLED if interval_reg=0.
  - `interval_wr` during FIRE updates interval_reg only; the pulse is never truncated.
- Priorities in the same cycle:
  - `interval_wr` over `kick`.
  - `kick` over expiry: `kick` on the expiring tick cycle prevents FIRE.
  - Expiry set over `status_rd` clear: status ends 1, `expire_cnt` ends 1.
- `rst` mid-pulse: `watchdog_rst` returns to 1 on the next edge; all state is cleared.
- Outputs are registered: no combinational path from any input to `watchdog_rst`.
- Counter width rule: interval_reg is 8 bits; the maximum timeout is 255·2^PRESCALE_BITS cycles.

Test Plan:
- PRESCALE_BITS=2, PULSE_LEN=4; reset, then no `interval_wr` → `watchdog_rst` stays 1 and `watchdog_status`=0 for 1000 cycles.
- Write `interval`=3, no `kick` → `watchdog_rst` low exactly 12 cycles after the write edge for 4 cycles; `watchdog_status`=1, `expire_cnt`=1; re-fires 12 cycles after the pulse ends, `expire_cnt`=2.
- `interval`=3, `kick` every 10 cycles for 200 cycles → `watchdog_rst` never low; `kick` on the exact expiring-tick cycle → no pulse.
- Mid-pulse write `interval`=0 → pulse still 4 cycles, then DISABLED; `status_rd` coincident with an expiry → `watchdog_status`=1, `expire_cnt`=1.
- Force 300 expiries with CNT_WIDTH=8 → `expire_cnt` saturates at 255; `status_rd` → `watchdog_status`=0, `expire_cnt`=0.
- Assert `rst` during the 2nd cycle of a pulse → `watchdog_rst`=1 next edge; interval_reg=0; no further pulses.

Source files
------------

// File: rtl/watchdog.sv
`default_nettype none
// ============================================================================
//  Module      : watchdog
//  Description : Decoder watchdog timer. Watches for progress strobes (kick)
//                and, if none arrives within a programmable interval of
//                prescaled ticks, drives an active-low reset pulse of fixed
//                length, then re-arms. The interval and status registers are
//                cleared only by rst, so they outlive the reset they cause.
//
//  Ports       : clk             decoder clock
//                rst             synchronous active-high reset (inverted hard reset)
//                kick            one-cycle progress strobe, restarts the timeout
//                interval[7:0]   timeout in ticks, 0 disables the watchdog
//                interval_wr     load interval into the interval register
//                status_rd       clears watchdog_status and expire_cnt
//                watchdog_rst    registered active-low watchdog reset
//                watchdog_status sticky "fired since last status_rd" flag
//                expire_cnt      saturating expiry count since last status_rd
//
//  Revision    : 1.0  initial release
// ============================================================================
module watchdog #(
    parameter int PRESCALE_BITS = 16,
    parameter int PULSE_LEN     = 4,
    parameter int CNT_WIDTH     = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 kick,
    input  logic [7:0]           interval,
    input  logic                 interval_wr,
    input  logic                 status_rd,
    output logic                 watchdog_rst,
    output logic                 watchdog_status,
    output logic [CNT_WIDTH-1:0] expire_cnt
);

    localparam int c_PULSE_W = (PULSE_LEN > 1) ? $clog2(PULSE_LEN) : 1;
    localparam logic [c_PULSE_W-1:0] c_PULSE_LAST = c_PULSE_W'(PULSE_LEN - 1);

    typedef enum logic [1:0] {
        ST_DISABLED = 2'd0,
        ST_RUNNING  = 2'd1,
        ST_FIRE     = 2'd2
    } state_t;

    state_t                   r_state;
    state_t                   w_state_nxt;
    logic [7:0]               r_interval;
    logic [7:0]               w_interval_nxt;
    logic [PRESCALE_BITS-1:0] r_prescaler;
    logic [PRESCALE_BITS-1:0] w_prescaler_nxt;
    logic [7:0]               r_counter;
    logic [7:0]               w_counter_nxt;
    logic [c_PULSE_W-1:0]     r_pulse;
    logic [c_PULSE_W-1:0]     w_pulse_nxt;
    logic                     r_watchdog_rst;
    logic                     w_watchdog_rst_nxt;
    logic                     r_status;
    logic                     w_status_nxt;
    logic [CNT_WIDTH-1:0]     r_expire_cnt;
    logic [CNT_WIDTH-1:0]     w_expire_cnt_nxt;

    logic                     w_tick;
    logic                     w_fire;
    logic                     w_status_base;
    logic [CNT_WIDTH-1:0]     w_cnt_base;

    assign w_tick = &r_prescaler;

    // A status read clears first; an expiry in the same cycle then sets on
    // top of the cleared values, so the expiry is never lost.
    assign w_status_base = status_rd ? 1'b0 : r_status;
    assign w_cnt_base    = status_rd ? '0 : r_expire_cnt;

    always_comb begin
        w_state_nxt        = r_state;
        w_interval_nxt     = r_interval;
        w_prescaler_nxt    = r_prescaler;
        w_counter_nxt      = r_counter;
        w_pulse_nxt        = r_pulse;
        w_watchdog_rst_nxt = r_watchdog_rst;
        w_fire             = 1'b0;

        case (r_state)
            ST_DISABLED: begin
                w_watchdog_rst_nxt = 1'b1;
                w_prescaler_nxt    = '0;
                if (interval_wr) begin
                    w_interval_nxt = interval;
                    if (interval != 8'd0) begin
                        w_state_nxt   = ST_RUNNING;
                        w_counter_nxt = interval;
                    end
                end
            end

            ST_RUNNING: begin
                // Prescaler free-runs and wraps to zero after all-ones.
                w_prescaler_nxt = r_prescaler + 1'b1;
                if (interval_wr) begin
                    w_interval_nxt  = interval;
                    w_prescaler_nxt = '0;
                    w_counter_nxt   = interval;
                    if (interval == 8'd0) begin
                        w_state_nxt = ST_DISABLED;
                    end
                end else if (kick) begin
                    w_prescaler_nxt = '0;
                    w_counter_nxt   = r_interval;
                end else if (w_tick) begin
                    if (r_counter > 8'd1) begin
                        w_counter_nxt = r_counter - 8'd1;
                    end else begin
                        w_fire             = 1'b1;
                        w_state_nxt        = ST_FIRE;
                        w_watchdog_rst_nxt = 1'b0;
                        w_pulse_nxt        = '0;
                    end
                end
            end

            ST_FIRE: begin
                w_watchdog_rst_nxt = 1'b0;
                w_pulse_nxt        = r_pulse + 1'b1;
                if (interval_wr) begin
                    w_interval_nxt = interval;
                end
                // The pulse always runs its full length; re-arm uses the
                // interval value that is in force as the pulse ends.
                if (r_pulse == c_PULSE_LAST) begin
                    w_watchdog_rst_nxt = 1'b1;
                    w_pulse_nxt        = '0;
                    w_prescaler_nxt    = '0;
                    w_counter_nxt      = w_interval_nxt;
                    w_state_nxt        = (w_interval_nxt == 8'd0) ? ST_DISABLED : ST_RUNNING;
                end
            end

            default: begin
                w_state_nxt        = ST_DISABLED;
                w_watchdog_rst_nxt = 1'b1;
                w_prescaler_nxt    = '0;
                w_counter_nxt      = '0;
                w_pulse_nxt        = '0;
            end
        endcase

        w_status_nxt     = w_status_base;
        w_expire_cnt_nxt = w_cnt_base;
        if (w_fire) begin
            w_status_nxt     = 1'b1;
            w_expire_cnt_nxt = (&w_cnt_base) ? w_cnt_base : w_cnt_base + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state        <= ST_DISABLED;
            r_interval     <= '0;
            r_prescaler    <= '0;
            r_counter      <= '0;
            r_pulse        <= '0;
            r_watchdog_rst <= 1'b1;
            r_status       <= 1'b0;
            r_expire_cnt   <= '0;
        end else begin
            r_state        <= w_state_nxt;
            r_interval     <= w_interval_nxt;
            r_prescaler    <= w_prescaler_nxt;
            r_counter      <= w_counter_nxt;
            r_pulse        <= w_pulse_nxt;
            r_watchdog_rst <= w_watchdog_rst_nxt;
            r_status       <= w_status_nxt;
            r_expire_cnt   <= w_expire_cnt_nxt;
        end
    end

    assign watchdog_rst    = r_watchdog_rst;
    assign watchdog_status = r_status;
    assign expire_cnt      = r_expire_cnt;

endmodule
`default_nettype wire
